ps2_rx: RTL and testbench

- Serial-in, parallel-out receiver for a PS/2 keyboard: the receive-side counterpart of the right-shifting, LSB-first PISO shift register.
- Synchronizes and deglitches the device-driven ps2_clk/ps2_data pins and deframes 11-bit frames (start, 8 data LSB-first, odd parity, stop).
- Presents each received byte with a valid/ack handshake to the game-control logic (key decode for piece movement).

---
 rtl/ps2_rx.sv | 143 ++++++++++++++
 tb/tb_ps2_rx.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx.sv
`timescale 1ns/1ps
// PS/2 keyboard receiver: synchronizes and deglitches the device pins, deframes
// 11-bit frames (start, LSB-first data, odd parity, stop) and hands bytes over via valid/ack.
module ps2_rx #(
  parameter int W              = 8,
  parameter int FILTER         = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         ps2_clk,
  input  logic         ps2_data,
  output logic [W-1:0] data_out,
  output logic         data_valid,
  input  logic         data_ack,
  output logic         parity_err,
  output logic         frame_err,
  output logic         overrun
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic          clk_p0, clk_p1, dat_p0, dat_p1;
  logic          fclk, fall;
  logic [3:0]    fcnt;
  state_t        state;
  logic [BW-1:0] nbit;
  logic [TW-1:0] tmo;
  logic [W-1:0]  q;
  logic          par;

  // Stage p0/p1: two-flop synchronizers, idle-high after reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_p0 <= 1'b1;
      clk_p1 <= 1'b1;
      dat_p0 <= 1'b1;
      dat_p1 <= 1'b1;
    end else begin
      clk_p0 <= ps2_clk;
      clk_p1 <= clk_p0;
      dat_p0 <= ps2_data;
      dat_p1 <= dat_p0;
    end
  end

  // Filtered clock: flips only after FILTER consecutive opposite samples
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fclk <= 1'b1;
      fcnt <= '0;
      fall <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (clk_p1 == fclk) begin
        fcnt <= '0;
      end else if (fcnt == 4'(FILTER - 1)) begin
        fclk <= clk_p1;
        fcnt <= '0;
        fall <= fclk;
      end else begin
        fcnt <= fcnt + 4'd1;
      end
    end
  end

  // Frame state machine, timeout and output handshake
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      nbit       <= '0;
      tmo        <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      if (data_valid && data_ack)
        data_valid <= 1'b0;

      if (state == IDLE || fall) begin
        tmo <= '0;
      end else if (tmo == TW'(TIMEOUT_CYCLES - 1)) begin
        state     <= IDLE;
        frame_err <= 1'b1;
        tmo       <= '0;
      end else begin
        tmo <= tmo + TW'(1);
      end

      if (fall) begin
        case (state)
          IDLE: begin
            if (!dat_p1) begin
              state <= DATA;
              nbit  <= '0;
            end else begin
              frame_err <= 1'b1;
            end
          end
          DATA: begin
            nbit <= nbit + BW'(1);
            if (nbit == BW'(W - 1))
              state <= PARITY;
          end
          PARITY: state <= STOP;
          STOP: begin
            state <= IDLE;
            if (!dat_p1) begin
              frame_err <= 1'b1;
            end else if (!(^q ^ par)) begin
              parity_err <= 1'b1;
            end else begin
              data_out   <= q;
              data_valid <= 1'b1;
              if (data_valid && !data_ack)
                overrun <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Shift register and parity capture (pure data, no reset needed)
  always_ff @(posedge clk) begin
    if (fall) begin
      if (state == DATA)
        q <= {dat_p1, q[W-1:1]};
      if (state == PARITY)
        par <= dat_p1;
    end
  end

endmodule

// File: tb/tb_ps2_rx.sv
`timescale 1ns/1ps
// Bench for ps2_rx: directed frame table, multi-cycle corner sequences and
// randomized frames checked against a byte-level reference model.
module tb_ps2_rx;

  localparam int W    = 8;
  localparam int FILT = 4;
  localparam int TMO  = 300;
  localparam int HALF = 20;

  logic         clk = 1'b0;
  logic         reset_n, ps2_clk, ps2_data, data_ack;
  logic [W-1:0] data_out;
  logic         data_valid, parity_err, frame_err, overrun;

  ps2_rx #(.W(W), .FILTER(FILT), .TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ack   (data_ack),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_perr = 0, n_ferr = 0, n_ovr = 0;

  always @(negedge clk) begin
    if (parity_err) n_perr++;
    if (frame_err)  n_ferr++;
    if (overrun)    n_ovr++;
  end

  logic         snap_valid;
  logic [W-1:0] snap_data;

  typedef struct {
    logic [7:0] d;
    bit         pflip;
    bit         stop;
    bit         ack_before;
    bit         ev;
    logic [7:0] ed;
    int         eperr;
    int         eferr;
    int         eovr;
  } vec_t;

  vec_t tbl[8];

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] mk(input logic [7:0] d, input bit pflip, input bit stop);
    logic p;
    p = ~(^d) ^ pflip;
    return {stop, p, d, 1'b0};
  endfunction

  task automatic do_ack();
    data_ack = 1'b1;
    cyc(1);
    data_ack = 1'b0;
  endtask

  // Drives nbits of a frame; the stop-bit fall snapshots the outputs FILT+4 cycles later
  task automatic send(input logic [10:0] fr, input int nbits, input bit glitch, input bit ack_at_stop);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = fr[i];
      if (glitch && i >= 2 && i <= 8) begin
        cyc(3);
        ps2_clk = 1'b0;
        cyc(FILT - 1);
        ps2_clk = 1'b1;
        cyc(HALF/2 - 3 - (FILT - 1));
      end else begin
        cyc(HALF/2);
      end
      ps2_clk = 1'b0;
      if (i == 10) begin
        if (ack_at_stop) begin
          cyc(FILT + 2);
          data_ack = 1'b1;
          cyc(1);
          data_ack = 1'b0;
          cyc(1);
        end else begin
          cyc(FILT + 4);
        end
        snap_valid = data_valid;
        snap_data  = data_out;
        cyc(HALF - (FILT + 4));
      end else begin
        cyc(HALF);
      end
      ps2_clk = 1'b1;
      cyc(HALF/2);
    end
    ps2_data = 1'b1;
    cyc(HALF);
  endtask

  initial begin
    int         p0, f0, o0;
    bit         mv;
    logic [7:0] md;
    logic [7:0] d;
    int         kind;
    bit         pf, st, ak;
    int         eperr, eferr, eovr;

    tbl[0] = '{8'h1C, 1'b0, 1'b1, 1'b0, 1'b1, 8'h1C, 0, 0, 0};
    tbl[1] = '{8'hF0, 1'b0, 1'b1, 1'b1, 1'b1, 8'hF0, 0, 0, 0};
    tbl[2] = '{8'h1C, 1'b0, 1'b1, 1'b0, 1'b1, 8'h1C, 0, 0, 1};
    tbl[3] = '{8'h1C, 1'b1, 1'b1, 1'b1, 1'b0, 8'h1C, 1, 0, 0};
    tbl[4] = '{8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 8'h1C, 0, 1, 0};
    tbl[5] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 8'h1C, 0, 1, 0};
    tbl[6] = '{8'h75, 1'b0, 1'b1, 1'b0, 1'b1, 8'h75, 0, 0, 0};
    tbl[7] = '{8'h12, 1'b1, 1'b1, 1'b0, 1'b1, 8'h75, 1, 0, 0};

    reset_n  = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    data_ack = 1'b0;
    cyc(3);
    chk("rst_valid", data_valid, 0);
    chk("rst_data", data_out, 0);
    chk("rst_perr", parity_err, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovr", overrun, 0);
    reset_n = 1'b1;
    cyc(5);

    for (int k = 0; k < 8; k++) begin
      if (tbl[k].ack_before) begin
        do_ack();
        chk($sformatf("v%0d_ack_clears", k), data_valid, 0);
      end
      p0 = n_perr; f0 = n_ferr; o0 = n_ovr;
      send(mk(tbl[k].d, tbl[k].pflip, tbl[k].stop), 11, 1'b0, 1'b0);
      chk($sformatf("v%0d_valid", k), data_valid, tbl[k].ev);
      chk($sformatf("v%0d_data", k), data_out, tbl[k].ed);
      chk($sformatf("v%0d_perr", k), n_perr - p0, tbl[k].eperr);
      chk($sformatf("v%0d_ferr", k), n_ferr - f0, tbl[k].eferr);
      chk($sformatf("v%0d_ovr", k), n_ovr - o0, tbl[k].eovr);
      if (tbl[k].eperr == 0 && tbl[k].eferr == 0) begin
        chk($sformatf("v%0d_lat_valid", k), snap_valid, 1);
        chk($sformatf("v%0d_lat_data", k), snap_data, tbl[k].d);
      end
    end

    // Accept and ack in the same cycle: new byte loaded, no overrun
    o0 = n_ovr;
    send(mk(8'h4B, 1'b0, 1'b1), 11, 1'b0, 1'b1);
    chk("same_ack_valid", snap_valid, 1);
    chk("same_ack_data", snap_data, 8'h4B);
    chk("same_ack_ovr", n_ovr - o0, 0);
    do_ack();

    // Clock stalls mid-frame -> timeout, then a clean frame
    p0 = n_perr; f0 = n_ferr;
    send(mk(8'h75, 1'b0, 1'b1), 5, 1'b0, 1'b0);
    chk("tmo_before", n_ferr - f0, 0);
    cyc(TMO + 10);
    chk("tmo_ferr", n_ferr - f0, 1);
    chk("tmo_perr", n_perr - p0, 0);
    chk("tmo_valid", data_valid, 0);
    f0 = n_ferr;
    send(mk(8'h75, 1'b0, 1'b1), 11, 1'b0, 1'b0);
    chk("post_tmo_valid", data_valid, 1);
    chk("post_tmo_data", data_out, 8'h75);
    chk("post_tmo_ferr", n_ferr - f0, 0);
    do_ack();

    // Short clock glitches must not count as bits
    p0 = n_perr; f0 = n_ferr; o0 = n_ovr;
    send(mk(8'h6B, 1'b0, 1'b1), 11, 1'b1, 1'b0);
    chk("glitch_valid", data_valid, 1);
    chk("glitch_data", data_out, 8'h6B);
    chk("glitch_errs", (n_perr - p0) + (n_ferr - f0) + (n_ovr - o0), 0);

    // Reset mid-frame clears outputs immediately and discards the partial frame
    send(mk(8'h2D, 1'b0, 1'b1), 5, 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("arst_valid", data_valid, 0);
    chk("arst_data", data_out, 0);
    cyc(3);
    reset_n = 1'b1;
    p0 = n_perr; f0 = n_ferr; o0 = n_ovr;
    send(mk(8'h2D, 1'b0, 1'b1), 11, 1'b0, 1'b0);
    chk("post_rst_valid", data_valid, 1);
    chk("post_rst_data", data_out, 8'h2D);
    chk("post_rst_errs", (n_perr - p0) + (n_ferr - f0) + (n_ovr - o0), 0);

    // Randomized frames against a byte-level model
    mv = 1'b1;
    md = 8'h2D;
    for (int r = 0; r < 24; r++) begin
      d    = 8'($urandom);
      kind = int'($urandom_range(0, 5));
      pf   = (kind == 0);
      st   = (kind != 1);
      ak   = ($urandom_range(0, 1) == 1);
      if (ak) begin
        do_ack();
        mv = 1'b0;
      end
      eperr = 0; eferr = 0; eovr = 0;
      if (!st) begin
        eferr = 1;
      end else if (pf) begin
        eperr = 1;
      end else begin
        eovr = mv ? 1 : 0;
        mv   = 1'b1;
        md   = d;
      end
      p0 = n_perr; f0 = n_ferr; o0 = n_ovr;
      send(mk(d, pf, st), 11, 1'b0, 1'b0);
      chk($sformatf("r%0d_valid", r), data_valid, mv);
      chk($sformatf("r%0d_data", r), data_out, md);
      chk($sformatf("r%0d_perr", r), n_perr - p0, eperr);
      chk($sformatf("r%0d_ferr", r), n_ferr - f0, eferr);
      chk($sformatf("r%0d_ovr", r), n_ovr - o0, eovr);
      if (eperr == 0 && eferr == 0)
        chk($sformatf("r%0d_lat_data", r), snap_data, d);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
